// File: rtl/pulse_period_monitor.sv
//------------------------------------------------------------------------------
// Module      : pulse_period_monitor
// Description : Checks a one-cycle tick stream. It measures the interval between
//               ticks, declares lock once intervals are in window, and flags
//               early or late ticks.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pulse_period_monitor #(
  parameter int EXPECTED   = 2,
  parameter int TOLERANCE  = 0,
  parameter int LOCK_COUNT = 4,
  parameter int BITS       = 8,
  parameter int ERR_BITS   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pulse_in,
  output logic [BITS-1:0]     period,
  output logic                period_valid,
  output logic                locked,
  output logic                error_early,
  output logic                error_late,
  output logic [ERR_BITS-1:0] err_count
);

  localparam int            c_GOOD_W   = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [BITS-1:0] c_LO       = BITS'(EXPECTED - TOLERANCE);
  localparam logic [BITS-1:0] c_HI       = BITS'(EXPECTED + TOLERANCE);
  localparam logic [BITS-1:0] c_CNT_ONE  = BITS'(1);
  localparam logic [BITS-1:0] c_CNT_MAX  = {BITS{1'b1}};
  localparam logic [c_GOOD_W-1:0] c_GOOD_ONE  = c_GOOD_W'(1);
  localparam logic [c_GOOD_W-1:0] c_LOCK_GOOD = c_GOOD_W'(LOCK_COUNT);
  localparam logic [ERR_BITS-1:0] c_ERR_ONE   = ERR_BITS'(1);
  localparam logic [ERR_BITS-1:0] c_ERR_MAX   = {ERR_BITS{1'b1}};

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACQUIRE = 2'd1;
  localparam logic [1:0] S_LOCKED  = 2'd2;

  logic [1:0]          r_state;
  logic [BITS-1:0]     r_cnt;
  logic [c_GOOD_W-1:0] r_good;
  logic                r_late_flagged;
  logic [BITS-1:0]     r_period;
  logic                r_period_valid;
  logic                r_locked;
  logic                r_error_early;
  logic                r_error_late;
  logic [ERR_BITS-1:0] r_err_count;

  logic [1:0]          w_state_next;
  logic [BITS-1:0]     w_cnt_next;
  logic [c_GOOD_W-1:0] w_good_next;
  logic [c_GOOD_W-1:0] w_good_inc;
  logic                w_late_flagged_next;
  logic [BITS-1:0]     w_period_next;
  logic                w_period_valid_next;
  logic                w_locked_next;
  logic                w_error_early_next;
  logic                w_error_late_next;
  logic [ERR_BITS-1:0] w_err_count_next;

  logic w_measuring;
  logic w_in_window;
  logic w_is_early;
  logic w_timeout;

  // r_cnt holds the interval length as seen in the cycle of the closing pulse
  assign w_measuring = (r_state == S_ACQUIRE) || (r_state == S_LOCKED);
  assign w_in_window = (r_cnt >= c_LO) && (r_cnt <= c_HI);
  assign w_is_early  = (r_cnt < c_LO);
  assign w_good_inc  = r_good + c_GOOD_ONE;
  assign w_timeout   = w_measuring && !pulse_in && (r_cnt == c_HI) && !r_late_flagged;

  assign w_cnt_next = pulse_in ? c_CNT_ONE :
                      (r_cnt == c_CNT_MAX) ? r_cnt : (r_cnt + c_CNT_ONE);

  // State register and all output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_good         <= '0;
      r_late_flagged <= 1'b0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_locked       <= 1'b0;
      r_error_early  <= 1'b0;
      r_error_late   <= 1'b0;
      r_err_count    <= '0;
    end else begin
      r_state        <= w_state_next;
      r_cnt          <= w_cnt_next;
      r_good         <= w_good_next;
      r_late_flagged <= w_late_flagged_next;
      r_period       <= w_period_next;
      r_period_valid <= w_period_valid_next;
      r_locked       <= w_locked_next;
      r_error_early  <= w_error_early_next;
      r_error_late   <= w_error_late_next;
      r_err_count    <= w_err_count_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next        = r_state;
    w_good_next         = r_good;
    w_late_flagged_next = r_late_flagged;
    case (r_state)
      S_IDLE: begin
        if (pulse_in) begin
          w_state_next        = S_ACQUIRE;
          w_good_next         = '0;
          w_late_flagged_next = 1'b0;
        end
      end
      S_ACQUIRE, S_LOCKED: begin
        if (pulse_in) begin
          w_late_flagged_next = 1'b0;
          if (w_in_window) begin
            if (r_state == S_ACQUIRE) begin
              w_good_next = w_good_inc;
              if (w_good_inc == c_LOCK_GOOD) begin
                w_state_next = S_LOCKED;
              end
            end
          end else begin
            w_good_next  = '0;
            w_state_next = S_ACQUIRE;
          end
        end else if (w_timeout) begin
          w_late_flagged_next = 1'b1;
          w_good_next         = '0;
          w_state_next        = S_ACQUIRE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_good_next  = '0;
      end
    endcase
  end

  // Output logic; values land in the output registers one cycle later
  always_comb begin
    w_period_next       = r_period;
    w_period_valid_next = 1'b0;
    w_error_early_next  = 1'b0;
    w_error_late_next   = 1'b0;
    w_locked_next       = (w_state_next == S_LOCKED);
    w_err_count_next    = r_err_count;
    if (w_measuring) begin
      if (pulse_in) begin
        w_period_next       = r_cnt;
        w_period_valid_next = 1'b1;
        w_error_early_next  = w_is_early;
      end else if (w_timeout) begin
        w_error_late_next = 1'b1;
      end
    end
    if ((w_error_early_next || w_error_late_next) && (r_err_count != c_ERR_MAX)) begin
      w_err_count_next = r_err_count + c_ERR_ONE;
    end
  end

  assign period       = r_period;
  assign period_valid = r_period_valid;
  assign locked       = r_locked;
  assign error_early  = r_error_early;
  assign error_late   = r_error_late;
  assign err_count    = r_err_count;

endmodule

`default_nettype wire
